// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin arbiter and access sequencer for the board
// async SRAM; NUM_RD read clients and one write client share one port.
module sram_arb_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 20,
  parameter int NUM_RD      = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk_100m,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_ack,
  inout  wire  [DATA_W-1:0]        ram_data,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W/8-1:0]      ram_be_n,
  output logic                     ram_ce_n,
  output logic                     ram_oe_n,
  output logic                     ram_we_n
);

  localparam int PTR_W = $clog2(NUM_RD + 1);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [PTR_W-1:0] WR_IDX = PTR_W'(NUM_RD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [NUM_RD-1:0] RD_ONE = NUM_RD'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    TURN
  } state_t;

  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [PTR_W-1:0] gnt, gnt_d;

  logic [NUM_RD:0] req_vec;
  logic hi_hit, lo_hit;
  logic [PTR_W-1:0] hi_idx, lo_idx, pick;
  logic [ADDR_W-1:0] rd_sel;
  logic wr_phase;
  logic drive_en;
  logic [DATA_W-1:0] dout;

  assign req_vec = {wr_req, rd_req};
  assign pick = hi_hit ? hi_idx : lo_idx;
  assign wr_phase = state inside {WR_SETUP, WR_PULSE, WR_HOLD};
  assign ram_data = drive_en ? dout : {DATA_W{1'bz}};

  // Round-robin search: lowest requester above ptr, else lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = NUM_RD; i >= 0; i--) begin
      if (req_vec[i]) begin
        if (PTR_W'(i) > ptr) begin
          hi_hit = 1'b1;
          hi_idx = PTR_W'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = PTR_W'(i);
        end
      end
    end
  end

  // Address of the currently granted read client.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (gnt == PTR_W'(i)) rd_sel = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ptr_d   = ptr;
    gnt_d   = gnt;
    unique case (state)
      IDLE: begin
        if (hi_hit || lo_hit) begin
          gnt_d   = pick;
          ptr_d   = pick;
          cnt_d   = '0;
          state_d = (pick == WR_IDX) ? WR_SETUP : RD;
        end
      end
      RD: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR_HOLD: state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, grant and round-robin pointer.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= WR_IDX;
      gnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
    end
  end

  // Pins are registered from the current state, one cycle behind it.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_be_n <= '1;
      ram_addr <= '0;
      drive_en <= 1'b0;
      dout     <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      wr_ack   <= 1'b0;
    end else begin
      ram_ce_n <= (state == IDLE);
      ram_oe_n <= (state != RD);
      ram_we_n <= (state != WR_PULSE);
      drive_en <= wr_phase;
      rd_valid <= '0;
      wr_ack   <= 1'b0;
      if (state == RD) begin
        ram_addr <= rd_sel;
        ram_be_n <= '0;
      end else if (wr_phase) begin
        ram_addr <= wr_addr;
        ram_be_n <= ~wr_be;
        dout     <= wr_data;
      end else begin
        ram_be_n <= '1;
      end
      if (state == TURN) begin
        if (gnt == WR_IDX) begin
          wr_ack <= 1'b1;
        end else begin
          rd_valid <= RD_ONE << gnt;
          rd_data  <= ram_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: scoreboard bench for sram_arb_ctrl with an SRAM model
// on a W=2/2-reader instance and a W=1/4-reader instance.
module tb_sram_arb_ctrl;

  localparam int W_A = 2;
  localparam int W_B = 1;

  typedef struct {
    bit          wr;
    int          client;
    logic [31:0] data;
    logic [3:0]  be_n;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        rst_a;
  logic [1:0]  rd_req_a;
  logic [39:0] rd_addr_a;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_valid_a;
  logic        wr_req_a;
  logic [19:0] wr_addr_a;
  logic [31:0] wr_data_a;
  logic [3:0]  wr_be_a;
  logic        wr_ack_a;
  wire  [31:0] ram_data_a;
  logic [19:0] ram_addr_a;
  logic [3:0]  ram_be_n_a;
  logic        ram_ce_n_a, ram_oe_n_a, ram_we_n_a;

  sram_arb_ctrl #(.DATA_W(32), .ADDR_W(20), .NUM_RD(2), .WAIT_CYCLES(W_A)) u_dut_a (
    .clk_100m(clk), .rst_n(rst_a),
    .rd_req(rd_req_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_req(wr_req_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .wr_be(wr_be_a), .wr_ack(wr_ack_a),
    .ram_data(ram_data_a), .ram_addr(ram_addr_a),
    .ram_be_n(ram_be_n_a), .ram_ce_n(ram_ce_n_a),
    .ram_oe_n(ram_oe_n_a), .ram_we_n(ram_we_n_a)
  );

  logic [31:0] mem_a [0:255];
  assign ram_data_a = (!ram_ce_n_a && !ram_oe_n_a) ?
                      mem_a[ram_addr_a[7:0]] : {32{1'bz}};

  always @(posedge clk) begin
    if (!ram_ce_n_a && !ram_we_n_a)
      for (int b = 0; b < 4; b++)
        if (!ram_be_n_a[b])
          mem_a[ram_addr_a[7:0]][b*8 +: 8] <= ram_data_a[b*8 +: 8];
  end

  // ---------------- instance B ----------------
  logic        rst_b;
  logic [3:0]  rd_req_b;
  logic [79:0] rd_addr_b;
  logic [31:0] rd_data_b;
  logic [3:0]  rd_valid_b;
  logic        wr_req_b;
  logic [19:0] wr_addr_b;
  logic [31:0] wr_data_b;
  logic [3:0]  wr_be_b;
  logic        wr_ack_b;
  wire  [31:0] ram_data_b;
  logic [19:0] ram_addr_b;
  logic [3:0]  ram_be_n_b;
  logic        ram_ce_n_b, ram_oe_n_b, ram_we_n_b;

  sram_arb_ctrl #(.DATA_W(32), .ADDR_W(20), .NUM_RD(4), .WAIT_CYCLES(W_B)) u_dut_b (
    .clk_100m(clk), .rst_n(rst_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_req(wr_req_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_be(wr_be_b), .wr_ack(wr_ack_b),
    .ram_data(ram_data_b), .ram_addr(ram_addr_b),
    .ram_be_n(ram_be_n_b), .ram_ce_n(ram_ce_n_b),
    .ram_oe_n(ram_oe_n_b), .ram_we_n(ram_we_n_b)
  );

  logic [31:0] mem_b [0:255];
  assign ram_data_b = (!ram_ce_n_b && !ram_oe_n_b) ?
                      mem_b[ram_addr_b[7:0]] : {32{1'bz}};

  always @(posedge clk) begin
    if (!ram_ce_n_b && !ram_we_n_b)
      for (int b = 0; b < 4; b++)
        if (!ram_be_n_b[b])
          mem_b[ram_addr_b[7:0]][b*8 +: 8] <= ram_data_b[b*8 +: 8];
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  exp_t sb_a[$];
  int oe_cnt = 0;
  int we_cnt = 0;
  logic [3:0] be_seen = 4'hx;
  logic [31:0] ref_b [0:3];
  int acks_b [0:4];

  // Monitor for instance A: scoreboard pop on every ack.
  always @(negedge clk) begin
    exp_t e;
    int act_id;
    if (!rst_a) begin
      oe_cnt = 0;
      we_cnt = 0;
    end else begin
      chk("a_oe_we_overlap", 32'(ram_oe_n_a | ram_we_n_a), 32'd1);
      if (!ram_oe_n_a) oe_cnt++;
      if (!ram_we_n_a) begin
        we_cnt++;
        be_seen = ram_be_n_a;
      end
      if (rd_valid_a != 2'b00 || wr_ack_a) begin
        if (sb_a.size() == 0) begin
          chk("a_unexpected_ack", {rd_valid_a, 29'd0, wr_ack_a}, 32'd0);
        end else begin
          e = sb_a.pop_front();
          act_id = wr_ack_a ? 2 : (rd_valid_a == 2'b01) ? 0 :
                   (rd_valid_a == 2'b10) ? 1 : 9;
          chk("a_grant", 32'(act_id), e.wr ? 32'd2 : 32'(e.client));
          if (e.wr) begin
            chk("a_be_n", 32'(be_seen), 32'(e.be_n));
            chk("a_we_width", 32'(we_cnt), 32'(W_A));
          end else begin
            chk("a_rd_data", rd_data_a, e.data);
            chk("a_oe_width", 32'(oe_cnt), 32'(W_A));
          end
          if (e.cyc >= 0) chk("a_latency", 32'(cyc), 32'(e.cyc));
        end
        oe_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  // Monitor for instance B: reads must see the last acked write.
  always @(negedge clk) begin
    logic [1:0] a;
    if (rst_b) begin
      chk("b_oe_we_overlap", 32'(ram_oe_n_b | ram_we_n_b), 32'd1);
      if (rd_valid_b != 4'd0) begin
        chk("b_onehot", 32'($onehot(rd_valid_b)), 32'd1);
        for (int c = 0; c < 4; c++) begin
          if (rd_valid_b[c]) begin
            a = rd_addr_b[c*20 +: 2];
            chk("b_rd_data", rd_data_b, ref_b[a]);
            acks_b[c]++;
          end
        end
      end
      if (wr_ack_b) begin
        for (int by = 0; by < 4; by++)
          if (wr_be_b[by])
            ref_b[wr_addr_b[1:0]][by*8 +: 8] = wr_data_b[by*8 +: 8];
        acks_b[4]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd_a(input int c, input logic [19:0] addr,
                      input logic [31:0] d);
    exp_t e;
    int t;
    repeat (3) @(negedge clk);
    rd_addr_a[c*20 +: 20] = addr;
    e = '{wr: 1'b0, client: c, data: d, be_n: 4'h0, cyc: cyc + W_A + 2};
    sb_a.push_back(e);
    rd_req_a[c] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rd_valid_a[c] && t < 50);
    rd_req_a[c] = 1'b0;
    if (!rd_valid_a[c]) begin
      chk("a_rd_timeout", 32'(rd_valid_a[c]), 32'd1);
      void'(sb_a.pop_back());
    end
  endtask

  task automatic wr_a(input logic [19:0] addr, input logic [31:0] d,
                      input logic [3:0] be);
    exp_t e;
    int t;
    repeat (3) @(negedge clk);
    wr_addr_a = addr;
    wr_data_a = d;
    wr_be_a   = be;
    e = '{wr: 1'b1, client: 2, data: d, be_n: ~be, cyc: cyc + W_A + 4};
    sb_a.push_back(e);
    wr_req_a = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wr_ack_a && t < 50);
    wr_req_a = 1'b0;
    if (!wr_ack_a) begin
      chk("a_wr_timeout", 32'(wr_ack_a), 32'd1);
      void'(sb_a.pop_back());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    int k, t;
    int left_b [0:4];
    int issued_b [0:4];
    bit done_b;
    rst_a = 1'b0; rst_b = 1'b0;
    rd_req_a = '0; rd_addr_a = '0; wr_req_a = 1'b0;
    wr_addr_a = '0; wr_data_a = '0; wr_be_a = '0;
    rd_req_b = '0; rd_addr_b = '0; wr_req_b = 1'b0;
    wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h5500_0000 | 32'(i);
      mem_b[i] = 32'h1000_0000 + 32'(i);
    end
    mem_a[8'h10] = 32'hDEADBEEF;
    mem_a[8'h11] = 32'hCAFEF00D;
    mem_a[8'h20] = 32'hAABBCCDD;
    mem_a[8'h21] = 32'h11111111;
    for (int i = 0; i < 4; i++) ref_b[i] = mem_b[i];
    for (int i = 0; i < 5; i++) begin
      acks_b[i] = 0;
      left_b[i] = 10;
      issued_b[i] = 0;
    end

    // Reset values while held, then idle after release.
    repeat (3) @(negedge clk);
    chk("rst_ce_n", 32'(ram_ce_n_a), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n_a), 32'd1);
    chk("rst_we_n", 32'(ram_we_n_a), 32'd1);
    chk("rst_be_n", 32'(ram_be_n_a), 32'hF);
    chk("rst_addr", 32'(ram_addr_a), 32'd0);
    chk("rst_bus_z", 32'(ram_data_a === {32{1'bz}}), 32'd1);
    chk("rst_rd_data", rd_data_a, 32'd0);
    chk("rst_acks", {rd_valid_a, wr_ack_a}, 32'd0);
    rst_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ce_n", 32'(ram_ce_n_a), 32'd1);
    chk("idle_oe_we", 32'(ram_oe_n_a & ram_we_n_a), 32'd1);
    chk("idle_bus_z", 32'(ram_data_a === {32{1'bz}}), 32'd1);

    // All clients requesting from reset: strict rotation rd0,rd1,wr.
    rst_a = 1'b0;
    @(negedge clk);
    rd_addr_a = {20'h00011, 20'h00010};
    wr_addr_a = 20'h00030;
    wr_data_a = 32'h5A5A5A5A;
    wr_be_a   = 4'hF;
    rd_req_a  = 2'b11;
    wr_req_a  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      e = '{wr: 1'b0, client: 0, data: 32'hDEADBEEF, be_n: 4'h0, cyc: -1};
      sb_a.push_back(e);
      e = '{wr: 1'b0, client: 1, data: 32'hCAFEF00D, be_n: 4'h0, cyc: -1};
      sb_a.push_back(e);
      e = '{wr: 1'b1, client: 2, data: 32'h5A5A5A5A, be_n: 4'h0, cyc: -1};
      sb_a.push_back(e);
    end
    @(negedge clk);
    rst_a = 1'b1;
    k = 0;
    t = 0;
    while (k < 6 && t < 200) begin
      @(negedge clk);
      t++;
      if (rd_valid_a != 2'b00 || wr_ack_a) k++;
    end
    rd_req_a = 2'b00;
    wr_req_a = 1'b0;
    chk("a_rotation_acks", 32'(k), 32'd6);
    chk("a_rotation_mem", mem_a[8'h30], 32'h5A5A5A5A);

    // Directed single accesses with exact latency.
    rd_a(0, 20'h00010, 32'hDEADBEEF);
    wr_a(20'h00020, 32'h12345678, 4'b0011);
    chk("a_wr_partial_mem", mem_a[8'h20], 32'hAABB5678);
    rd_a(1, 20'h00020, 32'hAABB5678);
    wr_a(20'h00021, 32'hFFFFFFFF, 4'b0000);
    chk("a_wr_be0_mem", mem_a[8'h21], 32'h11111111);
    rd_a(0, 20'h00021, 32'h11111111);

    // Asynchronous reset in the middle of the write pulse.
    repeat (3) @(negedge clk);
    wr_addr_a = 20'h00022;
    wr_data_a = 32'h0BADF00D;
    wr_be_a   = 4'hF;
    wr_req_a  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ram_we_n_a && t < 50);
    chk("a_we_seen", 32'(ram_we_n_a), 32'd0);
    #2 rst_a = 1'b0;
    #1;
    chk("a_arst_we_n", 32'(ram_we_n_a), 32'd1);
    chk("a_arst_ce_n", 32'(ram_ce_n_a), 32'd1);
    chk("a_arst_bus_z", 32'(ram_data_a === {32{1'bz}}), 32'd1);
    @(negedge clk);
    chk("a_arst_no_ack", 32'(wr_ack_a), 32'd0);
    @(negedge clk);
    e = '{wr: 1'b1, client: 2, data: 32'h0BADF00D, be_n: 4'h0, cyc: -1};
    sb_a.push_back(e);
    rst_a = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wr_ack_a && t < 50);
    wr_req_a = 1'b0;
    chk("a_reserviced_ack", 32'(wr_ack_a), 32'd1);
    chk("a_reserviced_mem", mem_a[8'h22], 32'h0BADF00D);
    repeat (3) @(negedge clk);
    chk("a_sb_empty", 32'(sb_a.size()), 32'd0);

    // Instance B: random back-to-back traffic on four readers and a writer.
    rst_b = 1'b1;
    done_b = 1'b0;
    t = 0;
    while (!done_b && t < 3000) begin
      @(negedge clk);
      t++;
      for (int c = 0; c < 4; c++) begin
        if (rd_req_b[c]) begin
          if (rd_valid_b[c]) rd_req_b[c] = 1'b0;
        end else if (left_b[c] > 0) begin
          rd_addr_b[c*20 +: 20] = 20'($urandom_range(0, 3));
          rd_req_b[c] = 1'b1;
          left_b[c]--;
          issued_b[c]++;
        end
      end
      if (wr_req_b) begin
        if (wr_ack_b) wr_req_b = 1'b0;
      end else if (left_b[4] > 0) begin
        wr_addr_b = 20'($urandom_range(0, 3));
        wr_data_b = $urandom;
        wr_be_b   = 4'($urandom_range(0, 15));
        wr_req_b  = 1'b1;
        left_b[4]--;
        issued_b[4]++;
      end
      done_b = (rd_req_b == 4'd0) && !wr_req_b;
      for (int c = 0; c < 5; c++) if (left_b[c] > 0) done_b = 1'b0;
    end
    chk("b_traffic_done", 32'(done_b), 32'd1);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++)
      chk($sformatf("b_ack_count_%0d", c), 32'(acks_b[c]), 32'(issued_b[c]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Parametrised, multi-client controller for the external asynchronous SRAM.
- Arbitrates NUM_RD read clients and one write client onto the single SRAM port, using round-robin with req/ack handshakes.
- Adds configurable access wait states, byte-enable writes, a bus-turnaround cycle and a full reset.
- Sits between the game/render logic and the board SRAM pins. Replaces the fixed-slot read/write controller.

Parameters:
- DATA_W, 32: SRAM data width. Must be a multiple of 8.
- ADDR_W, 20: SRAM word-address width.
- NUM_RD, 2: number of read clients, 1..8.
- WAIT_CYCLES, 2: cycles ram_oe_n/ram_we_n are held asserted per access. Must be >= 1.

Ports:
- clk_100m  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  NUM_RD  per-client read request; held high until that client's rd_valid.
- rd_addr  in  NUM_RD*ADDR_W  client i address at bits [i*ADDR_W +: ADDR_W]; stable while its req is high.
- rd_data  out  DATA_W  returned read data; valid when any rd_valid bit is high.
- rd_valid  out  NUM_RD  one-hot, one-cycle pulse; serves as both ack and data-valid.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables, active high.
- wr_ack  out  1  one-cycle pulse when the write is complete.
- ram_data  inout  DATA_W  SRAM data bus.
- ram_addr  out  ADDR_W  SRAM address.
- ram_be_n  out  DATA_W/8  SRAM byte enables, active low.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM controls, active low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE; ram_ce_n, ram_oe_n and ram_we_n = 1; ram_be_n all 1; ram_addr=0.
  - ram_data tri-stated; rd_data=0; rd_valid=0; wr_ack=0.
  - Round-robin pointer = NUM_RD (write slot), so read client 0 has first priority after reset.
- All SRAM pin outputs and rd_data are registered. No combinational path from client inputs to pins.
- Arbitration:
  - Evaluated only in IDLE. Requesters are indices 0..NUM_RD-1 (reads) and NUM_RD (write).
  - The search starts at pointer+1 and wraps. The first requester found is granted and the pointer is updated to it.
  - Requests arriving mid-access wait. No request is dropped.
- Read path (grant at edge k):
  - RD state for WAIT_CYCLES cycles: ram_addr=client address, ram_ce_n=0, ram_oe_n=0, ram_be_n all 0, bus tri-stated.
  - ram_data is sampled into rd_data on the last RD edge.
  - TURN state (1 cycle): ram_oe_n=1, rd_valid[i]=1. Then IDLE.
  - rd_valid rises W+1 cycles after edge k, where W = WAIT_CYCLES.
- Write path (grant at edge k):
  - WR_SETUP (1 cycle): addr, data and ~wr_be driven, ram_we_n=1.
  - WR_PULSE (W cycles): ram_we_n=0.
  - WR_HOLD (1 cycle): ram_we_n=1, data still driven.
  - TURN (1 cycle): bus released, wr_ack=1. Then IDLE.
  - wr_ack rises W+3 cycles after edge k.
- ram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; tri-stated otherwise. ram_oe_n and ram_we_n are never low together.
- ram_ce_n=0 in every state except IDLE.
- Requests sampled in IDLE come from clients that have already dropped req. A client seeing its ack in TURN must deassert by the IDLE cycle. A req still high in IDLE is treated as a new request.
- A write with wr_be=0 still runs the full sequence with ram_be_n all 1, and is acked.
- Simultaneous requests from all clients are serviced in strict rotation. No client waits more than NUM_RD other accesses.

Test Plan:
- Reset release, no requests -> ram_ce_n, ram_oe_n and ram_we_n stay 1; ram_data high-Z; pointer gives client 0 priority.
- Read client 0, addr 0x00010, SRAM model returns 0xDEADBEEF, W=2 -> ram_oe_n low for 2 cycles; rd_valid=2'b01 and rd_data=0xDEADBEEF exactly 3 cycles after acceptance.
- Write addr 0x00020, data 0x12345678, be=4'b0011, W=2 -> ram_we_n low for 2 cycles, ram_be_n=4'b1100; wr_ack 5 cycles after acceptance; model holds 0x????5678 (upper bytes unchanged).
- rd_req=2'b11 and wr_req=1 held continuously from reset -> grant order rd0, rd1, wr, rd0, ...; no bus overlap; ram_oe_n and ram_we_n never both 0.
- rst_n pulsed low during WR_PULSE -> ram_we_n goes to 1 and ram_data goes high-Z immediately, without waiting for a clock edge; no wr_ack; the write is re-serviced after reset if wr_req is still high.
- WAIT_CYCLES=1, NUM_RD=4, random back-to-back traffic against the SRAM model -> all reads return the last written data; ack counts equal request counts.
